hbridge_gate_driver: RTL and testbench
======================================

# hbridge_gate_driver

Gate-drive stage between the microstepper phase logic and the off-chip H-bridge of one motor coil. It converts a 2-bit coil drive request into the four active-high gate signals (high_1, low_1, high_2, low_2) of the full bridge. It enforces a programmable dead time on every pattern change and latches an overcurrent fault. Two instances are used per motor, one for coil A and one for coil B; their outputs go to the mprj_io phase pins.

## Interface
- DEAD_W, 8: width of the dead-time configuration and counter.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- phase_req  in  2  requested pattern: 00 coast, 01 forward, 10 reverse, 11 brake.
- polarity_invert_config  in  1  when 1, swaps forward and reverse before decode.
- deadtime  in  DEAD_W  dead time in clk cycles; 0 is treated as 1.
- fault  in  1  active-high overcurrent or shoot-through fault; synchronous to clk.
- fault_clear  in  1  single-cycle pulse that releases a latched fault.
- high_1, low_1, high_2, low_2  out  1 each  registered gate drives.
- applied  out  2  pattern currently driven onto the gates; 00 while dead, coasting or faulted.
- dead_active  out  1  high while waiting out dead time toward a non-coast request.
- fault_latched  out  1  high while in FAULT.

## Operation
Pattern decode, applied after the polarity swap:
- forward → high_1 and low_2 on.
- reverse → high_2 and low_1 on.
- brake → low_1 and low_2 on.
- coast → all gates off.
- A configuration with high_x and low_x both on for the same leg is illegal and must never reach the outputs.

States: OFF, DEAD, ON, FAULT.
- dead_cnt is a saturating counter of consecutive all-off cycles. It clears on any ON cycle and in FAULT.
- D = max(deadtime, 1), evaluated live every cycle.
- **OFF** (req = coast): gates off, dead_cnt counts.
  - Non-coast request with dead_cnt ≥ D → ON at that edge.
  - Non-coast request with dead_cnt < D → DEAD.
- **DEAD**: gates off, dead_cnt counts.
  - Target is the latest request; a request change does not restart the count.
  - dead_cnt reaches D → ON with the current request.
  - Request becomes coast → OFF.
- **ON**: pattern driven.
  - Request equal to applied → stay ON.
  - Any other request, including coast → gates off at that edge; go to DEAD, or OFF if coast; dead_cnt = 1.
- **FAULT**: gates off, applied = 00, fault_latched = 1.
  - Left only when fault_clear = 1 and fault = 0 in the same cycle → OFF with dead_cnt = 0.
  - fault_clear while fault = 1 is ignored.
- Priority per edge: reset > fault (enter FAULT from any state) > normal transitions.
- A change of polarity_invert_config while in ON changes the effective pattern, so it is treated as a request change and passes through dead time.

## Timing
- Reset values:
  - all four gates 0, applied = 00, dead_active = 0, fault_latched = 0
  - state OFF, dead_cnt = 0, so the first drive after reset waits D cycles.
- Inputs are sampled at the rising edge of clk; all outputs are registered.
- Pattern change from ON sampled at edge k:
  - gates all off after edge k, through edge k+D−1;
  - new pattern driven after edge k+D;
  - total all-off window exactly D cycles.
- From OFF with dead_cnt ≥ D: pattern driven after the sampling edge (1-cycle latency).
- Fault sampled at edge k: gates off after edge k. No dead time or other delay on the path to off.
- After a clear, the bridge is not re-driven for D cycles.
- Gates turning off never wait. Only turn-on is delayed.
- dead_cnt saturates at 2^DEAD_W−1. No wrap-around.
- deadtime changes while in DEAD: the compare uses the new value at the next edge. If dead_cnt already ≥ the new D, the pattern applies at that edge.

## Structure
- Shared constants go in constants.v:
  - PHASE_COAST, PHASE_FWD, PHASE_REV, PHASE_BRAKE;
  - state encodings for OFF, DEAD, ON, FAULT.
- No sub-module. The decode is a local function; the FSM and counter are a single always block.
- hbridge_coil in the bench consumes the outputs unchanged.
- Add an assertion in the bench: never (high_1 & low_1) and never (high_2 & low_2).

## Test plan
- Reset, deadtime = 4, phase_req = 01 held → gates all 0 for 4 cycles after reset release, then high_1 = low_2 = 1 and applied = 01.
- ON forward, request 10 at edge k, deadtime = 3 → gates off after edges k..k+2, high_2 = low_1 = 1 after edge k+3; no cycle with both gates of one leg on.
- Request toggles 01→10→11 during DEAD, deadtime = 5 → count not restarted; brake (low_1 = low_2 = 1) applied exactly 5 cycles after leaving ON.
- fault = 1 while ON → all gates 0 next cycle, fault_latched = 1. fault_clear while fault = 1 → no change. fault = 0 plus fault_clear → OFF, drive resumes after D cycles.
- deadtime = 0, request 01→10 → exactly one all-off cycle. polarity_invert_config = 1 with request 01 → high_2 = low_1 = 1.
- Coast for 10 cycles with deadtime = 4, then request 01 → pattern driven one cycle later with no extra dead time. dead_cnt saturates at 255 over a long coast without wrapping.

Source files
------------

// File: rtl/hbridge_gate_driver_pkg.sv
// Shared phase codes, FSM state encoding and gate decode for the H-bridge gate driver.
package hbridge_gate_driver_pkg;

  localparam logic [1:0] PHASE_COAST = 2'b00;
  localparam logic [1:0] PHASE_FWD   = 2'b01;
  localparam logic [1:0] PHASE_REV   = 2'b10;
  localparam logic [1:0] PHASE_BRAKE = 2'b11;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_DEAD  = 2'b01,
    ST_ON    = 2'b10,
    ST_FAULT = 2'b11
  } gd_state_e;

  // Swaps forward and reverse; coast and brake are symmetric.
  function automatic logic [1:0] polarity_swap(input logic [1:0] p);
    logic [1:0] r;
    r = p;
    if (p == PHASE_FWD)      r = PHASE_REV;
    else if (p == PHASE_REV) r = PHASE_FWD;
    return r;
  endfunction

  // Returns {high_1, low_1, high_2, low_2}; no code turns on both gates of a leg.
  function automatic logic [3:0] decode_gates(input logic [1:0] p);
    logic [3:0] g;
    g = 4'b0000;
    case (p)
      PHASE_FWD:   g = 4'b1001;
      PHASE_REV:   g = 4'b0110;
      PHASE_BRAKE: g = 4'b0101;
      default:     g = 4'b0000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/hbridge_gate_driver.sv
// Full-bridge gate driver: pattern decode, dead-time enforcement on every
// turn-on, and a latched overcurrent fault.
module hbridge_gate_driver
  import hbridge_gate_driver_pkg::*;
#(
  parameter int DEAD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        phase_req,
  input  logic              polarity_invert_config,
  input  logic [DEAD_W-1:0] deadtime,
  input  logic              fault,
  input  logic              fault_clear,
  output logic              high_1,
  output logic              low_1,
  output logic              high_2,
  output logic              low_2,
  output logic [1:0]        applied,
  output logic              dead_active,
  output logic              fault_latched
);

  localparam logic [DEAD_W-1:0] CNT_ONE = {{(DEAD_W-1){1'b0}}, 1'b1};

  gd_state_e         state_q, state_d;
  logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
  logic [1:0]        applied_q, applied_d;
  logic [3:0]        gates_q, gates_d;
  logic              dead_active_q, dead_active_d;
  logic              fault_latched_q, fault_latched_d;

  logic [1:0]        eff_req;
  logic [DEAD_W-1:0] dead_len;
  logic [DEAD_W-1:0] cnt_inc;

  always_comb begin
    eff_req  = polarity_invert_config ? polarity_swap(phase_req) : phase_req;
    dead_len = (deadtime == '0) ? CNT_ONE : deadtime;
    cnt_inc  = (dead_cnt_q == '1) ? dead_cnt_q : dead_cnt_q + CNT_ONE;

    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    applied_d  = applied_q;

    if (fault) begin
      state_d    = ST_FAULT;
      dead_cnt_d = '0;
      applied_d  = PHASE_COAST;
    end else begin
      case (state_q)
        // OFF and DEAD share the same rules; only the target request differs.
        ST_OFF, ST_DEAD: begin
          if (eff_req == PHASE_COAST) begin
            state_d    = ST_OFF;
            dead_cnt_d = cnt_inc;
            applied_d  = PHASE_COAST;
          end else if (dead_cnt_q >= dead_len) begin
            state_d    = ST_ON;
            dead_cnt_d = '0;
            applied_d  = eff_req;
          end else begin
            state_d    = ST_DEAD;
            dead_cnt_d = cnt_inc;
            applied_d  = PHASE_COAST;
          end
        end
        ST_ON: begin
          if (eff_req == applied_q) begin
            dead_cnt_d = '0;
          end else begin
            state_d    = (eff_req == PHASE_COAST) ? ST_OFF : ST_DEAD;
            dead_cnt_d = CNT_ONE;
            applied_d  = PHASE_COAST;
          end
        end
        ST_FAULT: begin
          dead_cnt_d = '0;
          applied_d  = PHASE_COAST;
          if (fault_clear) state_d = ST_OFF;
        end
        default: begin
          state_d    = ST_FAULT;
          dead_cnt_d = '0;
          applied_d  = PHASE_COAST;
        end
      endcase
    end

    gates_d         = decode_gates(applied_d);
    dead_active_d   = (state_d == ST_DEAD);
    fault_latched_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_OFF;
      dead_cnt_q      <= '0;
      applied_q       <= PHASE_COAST;
      gates_q         <= 4'b0000;
      dead_active_q   <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      dead_cnt_q      <= dead_cnt_d;
      applied_q       <= applied_d;
      gates_q         <= gates_d;
      dead_active_q   <= dead_active_d;
      fault_latched_q <= fault_latched_d;
    end
  end

  assign high_1        = gates_q[3];
  assign low_1         = gates_q[2];
  assign high_2        = gates_q[1];
  assign low_2         = gates_q[0];
  assign applied       = applied_q;
  assign dead_active   = dead_active_q;
  assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_hbridge_gate_driver.sv
// Self-checking bench for hbridge_gate_driver: directed scenarios plus random
// stimulus compared cycle by cycle against a behavioural bridge model.
module tb_hbridge_gate_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] phase_req;
  logic       polarity_invert_config;
  logic [7:0] deadtime;
  logic       fault;
  logic       fault_clear;
  logic       high_1, low_1, high_2, low_2;
  logic [1:0] applied;
  logic       dead_active;
  logic       fault_latched;

  hbridge_gate_driver #(.DEAD_W(8)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .phase_req              (phase_req),
    .polarity_invert_config (polarity_invert_config),
    .deadtime               (deadtime),
    .fault                  (fault),
    .fault_clear            (fault_clear),
    .high_1                 (high_1),
    .low_1                  (low_1),
    .high_2                 (high_2),
    .low_2                  (low_2),
    .applied                (applied),
    .dead_active            (dead_active),
    .fault_latched          (fault_latched)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    assert (!(high_1 && low_1) && !(high_2 && low_2))
      else $error("FAIL shoot_through: h1=%0b l1=%0b h2=%0b l2=%0b", high_1, low_1, high_2, low_2);
  end

  int vectors = 0;
  int miscompares = 0;

  // Model: what pattern is on the bridge, how long it has been fully off,
  // whether a fault is held, and whether we are waiting to turn on.
  int m_applied;
  int m_off_run;
  bit m_faulted;
  bit m_waiting;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int effective_request();
    int r;
    r = int'(phase_req);
    if (polarity_invert_config && (r == 1 || r == 2)) r = 3 - r;
    return r;
  endfunction

  task automatic model_edge();
    int d, e;
    d = (deadtime == 0) ? 1 : int'(deadtime);
    e = effective_request();
    if (reset) begin
      m_applied = 0; m_off_run = 0; m_faulted = 0; m_waiting = 0;
    end else if (fault) begin
      m_faulted = 1; m_applied = 0; m_off_run = 0; m_waiting = 0;
    end else if (m_faulted) begin
      if (fault_clear) m_faulted = 0;
      m_off_run = 0; m_waiting = 0;
    end else if (m_applied != 0) begin
      if (e != m_applied) begin
        m_applied = 0; m_off_run = 1; m_waiting = (e != 0);
      end else begin
        m_off_run = 0; m_waiting = 0;
      end
    end else if (e != 0 && m_off_run >= d) begin
      m_applied = e; m_off_run = 0; m_waiting = 0;
    end else begin
      m_off_run = (m_off_run + 1 > 255) ? 255 : m_off_run + 1;
      m_waiting = (e != 0);
    end
  endtask

  function automatic logic [15:0] expected_outs();
    logic h1, l1, h2, l2;
    logic [1:0] ap;
    h1 = (m_applied == 1);
    h2 = (m_applied == 2);
    l1 = (m_applied == 2 || m_applied == 3);
    l2 = (m_applied == 1 || m_applied == 3);
    ap = 2'(m_applied);
    return {7'd0, h1, l1, h2, l2, ap, m_waiting, m_faulted};
  endfunction

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check(tag, {7'd0, high_1, low_1, high_2, low_2, applied, dead_active, fault_latched},
          expected_outs());
  endtask

  initial begin
    reset = 1'b1;
    phase_req = 2'b01;
    polarity_invert_config = 1'b0;
    deadtime = 8'd4;
    fault = 1'b0;
    fault_clear = 1'b0;
    m_applied = 0; m_off_run = 0; m_faulted = 0; m_waiting = 0;

    repeat (2) cycle("reset");
    reset = 1'b0;
    repeat (8) cycle("startup_dead4");

    deadtime = 8'd3;
    phase_req = 2'b10;
    repeat (6) cycle("fwd_to_rev_dead3");

    deadtime = 8'd5;
    phase_req = 2'b01;
    cycle("retarget_fwd");
    phase_req = 2'b10;
    cycle("retarget_rev");
    phase_req = 2'b11;
    repeat (7) cycle("retarget_brake");

    fault = 1'b1;
    repeat (2) cycle("fault_enter");
    fault_clear = 1'b1;
    cycle("clear_while_fault");
    fault = 1'b0;
    cycle("clear_release");
    fault_clear = 1'b0;
    repeat (7) cycle("post_clear_dead");

    deadtime = 8'd0;
    phase_req = 2'b01;
    repeat (3) cycle("dead0_fwd");
    phase_req = 2'b10;
    repeat (3) cycle("dead0_rev");
    phase_req = 2'b01;
    polarity_invert_config = 1'b1;
    repeat (3) cycle("invert_fwd");
    polarity_invert_config = 1'b0;
    repeat (3) cycle("invert_off");

    deadtime = 8'd4;
    phase_req = 2'b00;
    repeat (10) cycle("long_coast");
    phase_req = 2'b01;
    repeat (2) cycle("coast_then_fwd");

    deadtime = 8'd255;
    phase_req = 2'b00;
    repeat (300) cycle("saturate_coast");
    phase_req = 2'b10;
    repeat (2) cycle("saturate_drive");

    deadtime = 8'd2;
    repeat (3000) begin
      if ($urandom_range(0, 99) < 25) phase_req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 5)  deadtime = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 99) < 2)  polarity_invert_config = ~polarity_invert_config;
      fault       = ($urandom_range(0, 99) < 2);
      fault_clear = ($urandom_range(0, 99) < 15);
      reset       = ($urandom_range(0, 999) < 2);
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
